// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall FSM, operand forwarding selects and a stall counter.
// Define HAZARD_FWD_EN for MEM/WB forwarding; otherwise RAW dependences stall decode.
package hazard_pkg;
    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        IMM    = 3'd1,
        LOAD   = 3'd2,
        STORE  = 3'd3,
        BRANCH = 3'd4,
        JUMP   = 3'd5,
        NOP    = 3'd6
    } OP_Code;
endpackage

module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_NO   = 32,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  OP_Code                    op_id,
    input  logic [$clog2(REG_NO)-1:0] src1,
    input  logic [$clog2(REG_NO)-1:0] src2,
    input  OP_Code                    op_ex,
    input  logic [$clog2(REG_NO)-1:0] dst_ex,
    input  logic                      wen_ex,
    input  logic [$clog2(REG_NO)-1:0] dst_mem,
    input  logic                      wen_mem,
    input  logic [$clog2(REG_NO)-1:0] dst_wb,
    input  logic                      wen_wb,
    input  logic                      flush,
    output logic                      Stall,
    output logic                      bubble,
    output logic [1:0]                fwd_a,
    output logic [1:0]                fwd_b,
    output logic [15:0]               stall_cycles
);

    localparam int unsigned RW = $clog2(REG_NO);
    // First STALL-state count; the IDLE cycle that detects the hazard is the first stall.
    localparam logic [2:0] CntInit = (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

    typedef enum logic [0:0] {StIdle, StStall} state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        use1, use2;
    logic        load_use;
    logic        dep_stall;
    logic        stall_raw;
    logic        counted;
    logic [1:0]  fwd_a_raw, fwd_b_raw;

    // Register 0 never matches: a nonzero source equal to dst implies dst is nonzero too.
    function automatic logic hit(input logic used, input logic [RW-1:0] src,
                                 input logic wen, input logic [RW-1:0] dst);
        return used && wen && (src != '0) && (src == dst);
    endfunction

    always_comb begin
        use1 = 1'b0;
        use2 = 1'b0;
        unique case (op_id)
            R_TYPE, STORE, BRANCH: begin
                use1 = 1'b1;
                use2 = 1'b1;
            end
            IMM, LOAD: use1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = (op_ex == LOAD) &&
                      (hit(use1, src1, 1'b1, dst_ex) || hit(use2, src2, 1'b1, dst_ex));

`ifdef HAZARD_FWD_EN
    logic unused_wen_ex;
    assign unused_wen_ex = wen_ex;
    assign dep_stall     = 1'b0;

    always_comb begin
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (hit(use1, src1, wen_mem, dst_mem)) begin
            fwd_a_raw = 2'b01;
        end else if (hit(use1, src1, wen_wb, dst_wb)) begin
            fwd_a_raw = 2'b10;
        end
        if (hit(use2, src2, wen_mem, dst_mem)) begin
            fwd_b_raw = 2'b01;
        end else if (hit(use2, src2, wen_wb, dst_wb)) begin
            fwd_b_raw = 2'b10;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{dst_wb, wen_wb};
    assign fwd_a_raw = 2'b00;
    assign fwd_b_raw = 2'b00;
    // Without bypass paths any in-flight producer in EX or MEM holds decode.
    assign dep_stall = hit(use1, src1, wen_ex, dst_ex)   || hit(use2, src2, wen_ex, dst_ex) ||
                       hit(use1, src1, wen_mem, dst_mem) || hit(use2, src2, wen_mem, dst_mem);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_cnt_d = stall_cnt_q;
        stall_raw   = 1'b0;
        counted     = 1'b0;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    stall_raw = load_use || dep_stall;
                    if (load_use) begin
                        counted = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = StStall;
                            cnt_d   = CntInit;
                        end
                    end
                end
                StStall: begin
                    stall_raw = 1'b1;
                    counted   = 1'b1;
                    if (cnt_q == 3'd0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            endcase
        end
        if (counted && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Reset overrides every combinational output.
    assign Stall        = Rst && stall_raw;
    assign bubble       = Stall;
    assign fwd_a        = Rst ? fwd_a_raw : 2'b00;
    assign fwd_b        = Rst ? fwd_b_raw : 2'b00;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three instances (LOAD_LAT 1, 3, 4) share one stimulus stream.
module tb_hazard_unit;
    import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    logic       Clk;
    logic       Rst;
    OP_Code     op_id, op_ex;
    logic [4:0] src1, src2, dst_ex, dst_mem, dst_wb;
    logic       wen_ex, wen_mem, wen_wb, flush;

    logic        stall_l1, stall_l3, stall_l4;
    logic        bubble_l1, bubble_l3, bubble_l4;
    logic [1:0]  fwd_a_l1, fwd_b_l1, fwd_a_l3, fwd_b_l3, fwd_a_l4, fwd_b_l4;
    logic [15:0] cnt_l1, cnt_l3, cnt_l4;

    int checks = 0;
    int errors = 0;

    hazard_unit #(.REG_NO(32), .LOAD_LAT(1)) u_lat1 (
        .Clk(Clk), .Rst(Rst), .op_id(op_id), .src1(src1), .src2(src2), .op_ex(op_ex),
        .dst_ex(dst_ex), .wen_ex(wen_ex), .dst_mem(dst_mem), .wen_mem(wen_mem),
        .dst_wb(dst_wb), .wen_wb(wen_wb), .flush(flush), .Stall(stall_l1),
        .bubble(bubble_l1), .fwd_a(fwd_a_l1), .fwd_b(fwd_b_l1), .stall_cycles(cnt_l1)
    );

    hazard_unit #(.REG_NO(32), .LOAD_LAT(3)) u_lat3 (
        .Clk(Clk), .Rst(Rst), .op_id(op_id), .src1(src1), .src2(src2), .op_ex(op_ex),
        .dst_ex(dst_ex), .wen_ex(wen_ex), .dst_mem(dst_mem), .wen_mem(wen_mem),
        .dst_wb(dst_wb), .wen_wb(wen_wb), .flush(flush), .Stall(stall_l3),
        .bubble(bubble_l3), .fwd_a(fwd_a_l3), .fwd_b(fwd_b_l3), .stall_cycles(cnt_l3)
    );

    hazard_unit #(.REG_NO(32), .LOAD_LAT(4)) u_lat4 (
        .Clk(Clk), .Rst(Rst), .op_id(op_id), .src1(src1), .src2(src2), .op_ex(op_ex),
        .dst_ex(dst_ex), .wen_ex(wen_ex), .dst_mem(dst_mem), .wen_mem(wen_mem),
        .dst_wb(dst_wb), .wen_wb(wen_wb), .flush(flush), .Stall(stall_l4),
        .bubble(bubble_l4), .fwd_a(fwd_a_l4), .fwd_b(fwd_b_l4), .stall_cycles(cnt_l4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        op_id   = NOP;
        op_ex   = NOP;
        src1    = 5'd0;
        src2    = 5'd0;
        dst_ex  = 5'd0;
        wen_ex  = 1'b0;
        dst_mem = 5'd0;
        wen_mem = 1'b0;
        dst_wb  = 5'd0;
        wen_wb  = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        idle();
        tick();
        Rst = 1'b1;
    endtask

    // Load in EX writing r5, consumer in decode reading r5 on the chosen slot.
    task automatic load_use(input OP_Code op, input logic [4:0] s1, input logic [4:0] s2);
        idle();
        op_ex  = LOAD;
        dst_ex = 5'd5;
        wen_ex = 1'b1;
        op_id  = op;
        src1   = s1;
        src2   = s2;
    endtask

    initial begin
        Rst = 1'b0;
        idle();

        // Reset masks outputs even with every hazard and forward condition present.
        load_use(R_TYPE, 5'd5, 5'd5);
        dst_mem = 5'd5;
        wen_mem = 1'b1;
        settle();
        check("rst_stall_l1", stall_l1, 0);
        check("rst_bubble_l1", bubble_l1, 0);
        check("rst_stall_l4", stall_l4, 0);
        check("rst_fwd_a", fwd_a_l1, 0);
        tick();
        check("rst_cnt_l1", cnt_l1, 0);
        check("rst_cnt_l4", cnt_l4, 0);
        Rst = 1'b1;
        idle();

        // R_TYPE src2 load-use: 1/3/4 stall cycles for the three latencies.
        load_use(R_TYPE, 5'd0, 5'd5);
        settle();
        check("lu_c0_l1", stall_l1, 1);
        check("lu_c0_bub_l1", bubble_l1, 1);
        check("lu_c0_l3", stall_l3, 1);
        check("lu_c0_l4", stall_l4, 1);
        tick();
        idle();
        settle();
        check("lu_c1_l1", stall_l1, 0);
        check("lu_c1_cnt_l1", cnt_l1, 1);
        check("lu_c1_l3", stall_l3, 1);
        check("lu_c1_l4", stall_l4, 1);
        tick();
        check("lu_c2_l3", stall_l3, 1);
        check("lu_c2_bub_l3", bubble_l3, 1);
        check("lu_c2_l4", stall_l4, 1);
        tick();
        check("lu_c3_l3", stall_l3, 0);
        check("lu_c3_cnt_l3", cnt_l3, 3);
        check("lu_c3_l4", stall_l4, 1);
        tick();
        check("lu_c4_l4", stall_l4, 0);
        check("lu_c4_cnt_l4", cnt_l4, 4);
        check("lu_c4_cnt_l1", cnt_l1, 1);

        // IMM src1 load-use on LOAD_LAT=3.
        do_reset();
        load_use(IMM, 5'd5, 5'd0);
        settle();
        check("imm_c0_l3", stall_l3, 1);
        tick();
        idle();
        settle();
        check("imm_c1_l3", stall_l3, 1);
        tick();
        check("imm_c2_l3", stall_l3, 1);
        tick();
        check("imm_c3_l3", stall_l3, 0);
        check("imm_c3_cnt_l3", cnt_l3, 3);
        tick();
        check("imm_c4_l3", stall_l3, 0);

        // A hazard still present on the first IDLE cycle starts a fresh stall.
        do_reset();
        load_use(BRANCH, 5'd5, 5'd1);
        settle();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reeval_c%0d_l3", i), stall_l3, 1);
            tick();
        end
        idle();
        settle();
        check("reeval_c5_l3", stall_l3, 1);
        tick();
        check("reeval_c6_l3", stall_l3, 0);
        check("reeval_cnt_l3", cnt_l3, 6);

        // Flush on the second stall cycle cancels the remaining stall.
        do_reset();
        load_use(STORE, 5'd2, 5'd5);
        settle();
        check("fl_c0_l3", stall_l3, 1);
        tick();
        idle();
        flush = 1'b1;
        settle();
        check("fl_c1_l3", stall_l3, 0);
        check("fl_c1_l4", stall_l4, 0);
        tick();
        flush = 1'b0;
        settle();
        check("fl_c2_l3", stall_l3, 0);
        check("fl_cnt_l3", cnt_l3, 1);
        load_use(R_TYPE, 5'd5, 5'd0);
        flush = 1'b1;
        settle();
        check("fl_idle_l1", stall_l1, 0);
        check("fl_idle_l3", stall_l3, 0);
        tick();
        idle();
        settle();
        check("fl_after_l3", stall_l3, 0);
        check("fl_after_cnt_l1", cnt_l1, 1);

        // Register 0 and unused sources never match.
        do_reset();
        idle();
        op_ex  = LOAD;
        dst_ex = 5'd0;
        wen_ex = 1'b1;
        op_id  = R_TYPE;
        settle();
        check("r0_l1", stall_l1, 0);
        check("r0_l4", stall_l4, 0);
        op_id  = IMM;
        src1   = 5'd3;
        src2   = 5'd7;
        dst_ex = 5'd7;
        settle();
        check("unused_src2_l1", stall_l1, 0);
        op_id = JUMP;
        src1  = 5'd7;
        settle();
        check("jump_src1_l4", stall_l4, 0);

        // MEM and WB both match src1: MEM wins; src2 unused for IMM.
        do_reset();
        idle();
        op_id   = IMM;
        src1    = 5'd9;
        src2    = 5'd9;
        dst_mem = 5'd9;
        wen_mem = 1'b1;
        dst_wb  = 5'd9;
        wen_wb  = 1'b1;
        settle();
        check("fwd_a_mem", fwd_a_l1, FwdEn ? 32'd1 : 32'd0);
        check("fwd_b_unused", fwd_b_l1, 0);
        check("dep_mem_stall", stall_l1, FwdEn ? 32'd0 : 32'd1);
        tick();
        check("dep_not_counted", cnt_l1, 0);
        wen_mem = 1'b0;
        settle();
        check("fwd_a_wb", fwd_a_l1, FwdEn ? 32'd2 : 32'd0);
        check("wb_no_stall", stall_l1, 0);
        idle();
        op_ex  = R_TYPE;
        dst_ex = 5'd4;
        wen_ex = 1'b1;
        op_id  = STORE;
        src2   = 5'd4;
        settle();
        check("dep_ex_stall_l1", stall_l1, FwdEn ? 32'd0 : 32'd1);
        check("dep_ex_stall_l4", stall_l4, FwdEn ? 32'd0 : 32'd1);
        check("dep_ex_fwd_b", fwd_b_l1, 0);
        tick();
        check("dep_ex_cnt_l4", cnt_l4, 0);
        idle();
        op_id  = BRANCH;
        src2   = 5'd6;
        dst_wb = 5'd6;
        wen_wb = 1'b1;
        settle();
        check("fwd_b_wb", fwd_b_l1, FwdEn ? 32'd2 : 32'd0);
        Rst = 1'b0;
        settle();
        check("rst_fwd_b", fwd_b_l1, 0);

        // Reset during a LOAD_LAT=4 stall abandons it.
        do_reset();
        load_use(R_TYPE, 5'd5, 5'd0);
        settle();
        check("rs_c0_l4", stall_l4, 1);
        tick();
        idle();
        settle();
        check("rs_c1_l4", stall_l4, 1);
        Rst = 1'b0;
        settle();
        check("rs_now_l4", stall_l4, 0);
        check("rs_now_bub_l4", bubble_l4, 0);
        tick();
        check("rs_cnt_l4", cnt_l4, 0);
        Rst = 1'b1;
        settle();
        check("rs_c2_l4", stall_l4, 0);
        tick();
        check("rs_c3_l4", stall_l4, 0);

        // Counter saturates after 65540 held stall cycles.
        do_reset();
        load_use(R_TYPE, 5'd5, 5'd5);
        repeat (65540) tick();
        check("sat_cnt_l1", cnt_l1, 32'hFFFF);
        check("sat_cnt_l4", cnt_l4, 32'hFFFF);
        check("sat_stall_l1", stall_l1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_NO, default 32: architectural register count; register index width RW = $clog2(REG_NO).
REQ-002 SHALL have parameter LOAD_LAT, default 1, legal 1..4: stall cycles per load-use hazard.
REQ-003 SHALL have ports, clock and reset first:
 - Clk  in  1  sole clock, rising edge.
 - Rst  in  1  reset, synchronous, active-low.
 - op_id  in  OP_Code  opcode class in decode.
 - src1, src2  in  RW  decode source registers.
 - op_ex  in  OP_Code  opcode class in execute.
 - dst_ex  in  RW  execute destination register.
 - wen_ex  in  1  execute writes a register.
 - dst_mem, wen_mem  in  RW, 1  memory-stage destination and write enable.
 - dst_wb, wen_wb  in  RW, 1  writeback destination and write enable.
 - flush  in  1  taken branch or jump resolved in execute.
 - Stall  out  1  hold PC and IF/ID.
 - bubble  out  1  insert NOP into ID/EX; always equals Stall.
 - fwd_a, fwd_b  out  2  operand source select: 00 regfile, 01 MEM, 10 WB.
 - stall_cycles  out  16  performance count of stalled cycles.

Function
REQ-004 SHALL treat src1 as used for R_TYPE, IMM, LOAD, STORE and BRANCH, and src2 as used for R_TYPE, STORE and BRANCH; unused sources never match.
REQ-005 SHALL never match, stall on or forward register 0.
REQ-006 SHALL detect a load-use hazard when op_ex==LOAD, dst_ex!=0 and dst_ex equals a used source.
REQ-007 SHALL implement FSM IDLE/STALL; reset state IDLE; 3-bit down-counter cnt, reset 0.
REQ-008 In IDLE on a load-use hazard: Stall=1 the same cycle (combinational, 0 latency); if LOAD_LAT>1, go to STALL with cnt=LOAD_LAT-2; else remain IDLE.
REQ-009 In STALL: Stall=1 and decode inputs ignored; decrement cnt; when cnt==0, return to IDLE the next cycle.
REQ-010 Each load-use hazard SHALL give exactly LOAD_LAT consecutive Stall cycles.
REQ-011 flush=1 SHALL force Stall=0 that cycle, and the FSM SHALL enter IDLE with cnt=0 on the next edge; flush has priority over all hazards.
REQ-012 A hazard present on the first IDLE cycle after STALL SHALL be re-evaluated as a new hazard.
REQ-013 stall_cycles SHALL increment on each edge where Stall=1 and saturate at 0xFFFF.
REQ-014 fwd_a/fwd_b SHALL be combinational from current inputs; if MEM and WB both match, MEM wins.

Reset
REQ-015 While Rst=0 at a rising edge: state=IDLE, cnt=0, stall_cycles=0.
REQ-016 Whenever Rst=0: Stall=0, bubble=0, fwd_a=fwd_b=00, regardless of other inputs.
REQ-017 Reset during STALL SHALL abandon the stall with no further Stall cycles.

Configuration
REQ-018 Macro HAZARD_FWD_EN SHALL select forwarding.
REQ-019 With HAZARD_FWD_EN: fwd_x=01 when wen_mem, dst_mem!=0 and dst_mem equals the used source; else 10 on the same test against WB; else 00.
REQ-020 Without HAZARD_FWD_EN: fwd_a=fwd_b=00, and Stall=1 combinationally in IDLE whenever a used source matches dst_ex (wen_ex) or dst_mem (wen_mem). This stall is not counted, and its dst_ex match is not treated as a load-use hazard. The LOAD_LAT rule still governs LOAD in execute.

Verification
REQ-021 LOAD_LAT=1, op_ex=LOAD dst_ex=5, op_id=R_TYPE src2=5 -> Stall=1 for 1 cycle; stall_cycles=1.
REQ-022 LOAD_LAT=3, same hazard with op_id=IMM src1=5 -> Stall=1 for exactly 3 cycles, then 0; FSM back in IDLE.
REQ-023 LOAD_LAT=3, flush=1 on second stall cycle -> Stall=0 that cycle and after; stall_cycles=1.
REQ-024 op_ex=LOAD dst_ex=0, src1=0 -> Stall=0; op_id=IMM, src2=dst_ex=7 -> Stall=0.
REQ-025 HAZARD_FWD_EN, src1=9, dst_mem=9 wen_mem=1, dst_wb=9 wen_wb=1 -> fwd_a=01; with wen_mem=0 -> fwd_a=10; without macro -> fwd_a=00 and Stall=1.
REQ-026 Rst=0 asserted mid-stall with LOAD_LAT=4 -> Stall=0 immediately, stall_cycles=0 after the edge; 65540 forced stall cycles -> stall_cycles=0xFFFF.
